// File: rtl/stack_pointer_unit.sv
// Stack pointer register with push/pop/load control, stack memory addressing and status flags.
// Overflow/underflow guarding (FULL and sticky FAULT states) is compiled in with `define SPU_STACK_GUARD_EN.
module stack_pointer_unit #(
  parameter logic [7:0] SP_TOP   = 8'hFF,
  parameter logic [7:0] SP_LIMIT = 8'hC0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LSP,
  input  logic       DSP,
  input  logic       ISP,
  input  logic [7:0] sp_load_val,
  output logic [7:0] SP_out,
  output logic [7:0] mem_addr,
  output logic       empty,
  output logic       full,
  output logic       fault,
  output logic [7:0] depth
);

  logic [7:0] sp_q;
  logic       dec;
  logic       inc;

  // Simultaneous push and pop cancel out and leave SP untouched.
  assign dec = DSP & ~ISP;
  assign inc = ISP & ~DSP;

`ifdef SPU_STACK_GUARD_EN

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ACTIVE,
    S_FULL,
    S_FAULT
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] sp_d;

  function automatic state_t classify(input logic [7:0] sp);
    if (sp == SP_TOP)                         return S_EMPTY;
    else if (sp == SP_LIMIT)                  return S_FULL;
    else if (sp > SP_LIMIT && sp < SP_TOP)    return S_ACTIVE;
    else                                      return S_FAULT;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= SP_TOP;
      state_q <= S_EMPTY;
    end else begin
      sp_q    <= sp_d;
      state_q <= state_d;
    end
  end

  // NOTE: hold values are assigned first so no path through this block infers a latch.
  always_comb begin
    sp_d    = sp_q;
    state_d = state_q;
    if (LSP) begin
      sp_d    = sp_load_val;
      state_d = classify(sp_load_val);
    end else if (state_q != S_FAULT) begin
      if (dec) begin
        if (state_q == S_FULL) begin
          state_d = S_FAULT;
        end else begin
          sp_d    = sp_q - 8'd1;
          state_d = classify(sp_q - 8'd1);
        end
      end else if (inc) begin
        if (state_q == S_EMPTY) begin
          state_d = S_FAULT;
        end else begin
          sp_d    = sp_q + 8'd1;
          state_d = classify(sp_q + 8'd1);
        end
      end
    end
  end

  always_comb begin
    empty = (state_q == S_EMPTY);
    full  = (state_q == S_FULL);
    fault = (state_q == S_FAULT);
  end

`else

  // Unguarded build: SP simply wraps modulo 256.
  always_ff @(posedge clk) begin
    if (rst)       sp_q <= SP_TOP;
    else if (LSP)  sp_q <= sp_load_val;
    else if (dec)  sp_q <= sp_q - 8'd1;
    else if (inc)  sp_q <= sp_q + 8'd1;
  end

  assign empty = (sp_q == SP_TOP);
  assign full  = 1'b0;
  assign fault = 1'b0;

`endif

  assign SP_out   = sp_q;
  assign mem_addr = dec ? (sp_q - 8'd1) : sp_q;
  assign depth    = SP_TOP - sp_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Scoreboard bench for stack_pointer_unit: driver queues hand-computed expectations, monitor compares each cycle.
module tb_stack_pointer_unit;

`ifdef SPU_STACK_GUARD_EN
  localparam bit G = 1'b1;
`else
  localparam bit G = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, LSP, DSP, ISP;
  logic [7:0] sp_load_val;
  logic [7:0] SP_out, mem_addr, depth;
  logic       empty, full, fault;

  typedef struct packed {
    logic [7:0] sp;
    logic [7:0] mem;
    logic [7:0] dep;
    logic       emp;
    logic       ful;
    logic       flt;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_vec  = 0;

  stack_pointer_unit dut (
    .clk        (clk),
    .rst        (rst),
    .LSP        (LSP),
    .DSP        (DSP),
    .ISP        (ISP),
    .sp_load_val(sp_load_val),
    .SP_out     (SP_out),
    .mem_addr   (mem_addr),
    .empty      (empty),
    .full       (full),
    .fault      (fault),
    .depth      (depth)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int vec, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h expected %h", vec, name, act, exp);
    end
  endtask

  // Expectation describes the outputs during the cycle these inputs are applied.
  task automatic step(input bit r, input bit l, input bit d, input bit i, input logic [7:0] v,
                      input logic [7:0] esp, input logic [7:0] emem,
                      input bit ee, input bit ef, input bit eflt);
    @(negedge clk);
    rst = r; LSP = l; DSP = d; ISP = i; sp_load_val = v;
    q.push_back('{sp: esp, mem: emem, dep: 8'hFF - esp, emp: ee, ful: ef, flt: eflt});
  endtask

  // Monitor: sample mid-low-phase, after the driver has settled inputs.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        check("SP_out",   n_vec, SP_out,   e.sp);
        check("mem_addr", n_vec, mem_addr, e.mem);
        check("depth",    n_vec, depth,    e.dep);
        check("empty",    n_vec, {7'd0, empty}, {7'd0, e.emp});
        check("full",     n_vec, {7'd0, full},  {7'd0, e.ful});
        check("fault",    n_vec, {7'd0, fault}, {7'd0, e.flt});
      end
    end
  end

  initial begin : driver
    rst = 1'b1; LSP = 1'b0; DSP = 1'b0; ISP = 1'b0; sp_load_val = 8'h00;
    @(posedge clk);
    //    r  l  d  i  val    sp             mem            e       f   flt
    step(0, 0, 1, 0, 8'h00, 8'hFF,         8'hFE,         1,      0,  0);   // reset state, first push
    step(0, 0, 1, 0, 8'h00, 8'hFE,         8'hFD,         0,      0,  0);
    step(0, 0, 1, 0, 8'h00, 8'hFD,         8'hFC,         0,      0,  0);
    step(0, 0, 0, 0, 8'h00, 8'hFC,         8'hFC,         0,      0,  0);   // depth 3
    step(0, 0, 0, 1, 8'h00, 8'hFC,         8'hFC,         0,      0,  0);
    step(0, 0, 0, 1, 8'h00, 8'hFD,         8'hFD,         0,      0,  0);
    step(0, 0, 0, 1, 8'h00, 8'hFE,         8'hFE,         0,      0,  0);
    step(0, 0, 0, 1, 8'h00, 8'hFF,         8'hFF,         1,      0,  0);   // underflow pop
    step(0, 0, 1, 0, 8'h00, G ? 8'hFF : 8'h00, G ? 8'hFE : 8'hFF, 0, 0, G); // push ignored in fault
    step(0, 1, 0, 0, 8'hC1, 8'hFF,         8'hFF,         !G,     0,  G);
    step(0, 0, 1, 0, 8'h00, 8'hC1,         8'hC0,         0,      0,  0);
    step(0, 0, 1, 0, 8'h00, 8'hC0,         8'hBF,         0,      G,  0);   // overflow push
    step(0, 1, 0, 0, 8'hE0, G ? 8'hC0 : 8'hBF, G ? 8'hC0 : 8'hBF, 0, 0, G);
    step(0, 1, 0, 0, 8'hF0, 8'hE0,         8'hE0,         0,      0,  0);   // depth 1F
    step(0, 0, 1, 1, 8'h00, 8'hF0,         8'hF0,         0,      0,  0);   // push+pop no-op x4
    step(0, 0, 1, 1, 8'h00, 8'hF0,         8'hF0,         0,      0,  0);
    step(0, 0, 1, 1, 8'h00, 8'hF0,         8'hF0,         0,      0,  0);
    step(0, 0, 1, 1, 8'h00, 8'hF0,         8'hF0,         0,      0,  0);
    step(0, 1, 0, 0, 8'h10, 8'hF0,         8'hF0,         0,      0,  0);   // out-of-range load
    step(0, 1, 0, 0, 8'hFF, 8'h10,         8'h10,         0,      0,  G);
    step(0, 0, 0, 1, 8'h00, 8'hFF,         8'hFF,         1,      0,  0);   // pop from top
    step(1, 1, 0, 0, 8'hC0, G ? 8'hFF : 8'h00, G ? 8'hFF : 8'h00, 0, 0, G); // rst beats LSP
    step(0, 1, 0, 0, 8'hC0, 8'hFF,         8'hFF,         1,      0,  0);
    step(0, 0, 0, 1, 8'h00, 8'hC0,         8'hC0,         0,      G,  0);   // pop from full
    step(0, 0, 0, 0, 8'h00, 8'hC1,         8'hC1,         0,      0,  0);

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
